serial_subtractor: RTL and testbench

- Bit-serial two's-complement subtractor: computes D = A - B - Bin, one bit per clock, LSB first, through a single full-adder cell.
- It is the inverse-operation companion to the team's ripple-carry adders: same operand format, but a sequential, area-minimal datapath with a start/done handshake.
- Feeds the lab ALU datapath wherever a multi-cycle subtract is acceptable.

---
 rtl/serial_subtractor.sv | 145 ++++++++++++++
 tb/tb_serial_subtractor.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: D = A - B - Bin, one bit per clock, LSB first.
// Define SERIAL_SUB_ADD_EN to add an add_sel port that switches the same cell to A + B + Bin.
module serial_subtractor #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
`ifdef SERIAL_SUB_ADD_EN
    input  logic             add_sel,
`endif
    output logic [WIDTH-1:0] D,
    output logic             Bout,
    output logic             V,
    output logic             Z,
    output logic             N,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [WIDTH-1:0] r_aReg;
    logic [WIDTH-1:0] r_bReg;
    logic [WIDTH-1:0] r_res;
    logic [CW-1:0]    r_cnt;
    logic             r_cy;
    logic             r_aMsb;
    logic             r_bMsb;

    logic             w_isAdd;
    logic             w_accept;
    logic             w_last;
    logic             w_bEff;
    logic             w_cIn;
    logic             w_cOut;
    logic             w_bit;
    logic             w_cyNext;
    logic             w_v;
    logic [WIDTH-1:0] w_dFinal;

`ifdef SERIAL_SUB_ADD_EN
    logic r_add;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_add <= 1'b0;
        end else if (w_accept) begin
            r_add <= add_sel;
        end
    end

    assign w_isAdd = r_add;
`else
    assign w_isAdd = 1'b0;
`endif

    // In subtract mode the flop holds borrow, so both b and the flop are inverted around the cell.
    assign w_bEff   = r_bReg[0] ^ ~w_isAdd;
    assign w_cIn    = r_cy ^ ~w_isAdd;
    assign w_bit    = r_aReg[0] ^ w_bEff ^ w_cIn;
    assign w_cOut   = (r_aReg[0] & w_bEff) | (r_aReg[0] & w_cIn) | (w_bEff & w_cIn);
    assign w_cyNext = w_cOut ^ ~w_isAdd;
    assign w_dFinal = {w_bit, r_res[WIDTH-1:1]};
    assign w_v      = (r_aMsb ^ r_bMsb ^ w_isAdd) & (w_bit ^ r_aMsb);

    assign w_accept = start && (r_state != SHIFT);
    assign w_last   = (r_state == SHIFT) && (r_cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start) w_next = SHIFT;
            SHIFT:   if (w_last) w_next = DONE;
            DONE:    w_next = start ? SHIFT : IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_aReg <= '0;
            r_bReg <= '0;
            r_res  <= '0;
            r_cnt  <= '0;
            r_cy   <= 1'b0;
            r_aMsb <= 1'b0;
            r_bMsb <= 1'b0;
        end else if (w_accept) begin
            r_aReg <= A;
            r_bReg <= B;
            r_cy   <= Bin;
            r_cnt  <= '0;
            r_aMsb <= A[WIDTH-1];
            r_bMsb <= B[WIDTH-1];
        end else if (r_state == SHIFT) begin
            r_aReg <= r_aReg >> 1;
            r_bReg <= r_bReg >> 1;
            r_res  <= w_dFinal;
            r_cy   <= w_cyNext;
            r_cnt  <= r_cnt + CW'(1);
        end
    end

    // Results are committed on the final shift edge so they are already valid in the DONE cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            D    <= '0;
            Bout <= 1'b0;
            V    <= 1'b0;
            Z    <= 1'b0;
            N    <= 1'b0;
        end else if (w_last) begin
            D    <= w_dFinal;
            Bout <= w_cyNext;
            V    <= w_v;
            Z    <= ~|w_dFinal;
            N    <= w_bit;
        end
    end

    assign busy = (r_state == SHIFT);
    assign done = (r_state == DONE);

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: directed vectors push expected results, a monitor checks each done.
// Add-mode vectors are included when SERIAL_SUB_ADD_EN is defined.
module tb_serial_subtractor;

    localparam int W       = 16;
    localparam int MAXWAIT = 40;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] A     = '0;
    logic [W-1:0] B     = '0;
    logic         Bin   = 1'b0;
    logic [W-1:0] D;
    logic         Bout;
    logic         V;
    logic         Z;
    logic         N;
    logic         busy;
    logic         done;
`ifdef SERIAL_SUB_ADD_EN
    logic         addSel = 1'b0;
`endif

    int   compared   = 0;
    int   mismatched = 0;
    int   busyCnt    = 0;
    logic prevDone   = 1'b0;

    typedef struct packed {
        logic [W-1:0] d;
        logic         bout;
        logic         v;
        logic         z;
        logic         n;
    } exp_t;

    exp_t expQ[$];

    serial_subtractor #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .A      (A),
        .B      (B),
        .Bin    (Bin),
`ifdef SERIAL_SUB_ADD_EN
        .add_sel(addSel),
`endif
        .D      (D),
        .Bout   (Bout),
        .V      (V),
        .Z      (Z),
        .N      (N),
        .busy   (busy),
        .done   (done)
    );

    always #5 clk = ~clk;

    function automatic exp_t mk(input logic [W-1:0] d, input logic bout, input logic v,
                                input logic z, input logic n);
        exp_t e;
        e.d    = d;
        e.bout = bout;
        e.v    = v;
        e.z    = z;
        e.n    = n;
        return e;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_D"},    64'(D),    64'(0));
        checkOutput({tag, "_Bout"}, 64'(Bout), 64'(0));
        checkOutput({tag, "_V"},    64'(V),    64'(0));
        checkOutput({tag, "_Z"},    64'(Z),    64'(0));
        checkOutput({tag, "_N"},    64'(N),    64'(0));
        checkOutput({tag, "_busy"}, 64'(busy), 64'(0));
        checkOutput({tag, "_done"}, 64'(done), 64'(0));
    endtask

    // Drives one accepted start, then scrambles the operand inputs so late changes would corrupt a bad design.
    task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                                 input logic push, input exp_t e);
        A     = a;
        B     = b;
        Bin   = bin;
        start = 1'b1;
        if (push) expQ.push_back(e);
        @(posedge clk);
        #1;
        start = 1'b0;
        A     = ~a;
        B     = a ^ b ^ 16'h5555;
        Bin   = ~bin;
    endtask

    // Counts edges after the accepting edge until done is seen.
    task automatic waitDone(input string name, input int expEdges);
        int n    = 0;
        bit seen = 1'b0;
        while (!seen && n < MAXWAIT) begin
            @(posedge clk);
            #1;
            n++;
            if (done) seen = 1'b1;
        end
        if (!seen) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL %s_timeout: no done after %0d cycles, expected after %0d", name, n, expEdges);
        end else begin
            checkOutput({name, "_latency"}, 64'(n), 64'(expEdges));
        end
    endtask

    task automatic idle(input int cycles);
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    // Monitor: pops the oldest expected result on every done and checks pulse shape and busy length.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst_n) begin
            busyCnt  = 0;
            prevDone = 1'b0;
        end else begin
            if (busy) busyCnt++;
            if (done) begin
                checkOutput("done_single_pulse", 64'(prevDone), 64'(0));
                checkOutput("busy_low_in_done",  64'(busy),     64'(0));
                if (expQ.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("[TB] FAIL unexpected_done: got done=1 with D=%0h, expected no pending result", D);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("D",           64'(D),       64'(e.d));
                    checkOutput("Bout",        64'(Bout),    64'(e.bout));
                    checkOutput("V",           64'(V),       64'(e.v));
                    checkOutput("Z",           64'(Z),       64'(e.z));
                    checkOutput("N",           64'(N),       64'(e.n));
                    checkOutput("busy_cycles", 64'(busyCnt), 64'(W));
                end
                busyCnt = 0;
            end
            prevDone = done;
        end
    end

    initial begin
        #12;
        checkAllZero("reset");
        rst_n = 1'b1;
        idle(2);

        // Abort mid-shift: no done may follow, and outputs must clear immediately.
        applyStimulus(16'h1234, 16'h0001, 1'b0, 1'b0, mk(16'h0, 1'b0, 1'b0, 1'b0, 1'b0));
        idle(4);
        rst_n = 1'b0;
        #1;
        checkAllZero("abort");
        idle(2);
        rst_n = 1'b1;
        idle(25);

        applyStimulus(16'h1234, 16'h0234, 1'b0, 1'b1, mk(16'h1000, 1'b0, 1'b0, 1'b0, 1'b0));
        waitDone("basic", W);
        idle(2);

        applyStimulus(16'h0000, 16'h0001, 1'b0, 1'b1, mk(16'hFFFF, 1'b1, 1'b0, 1'b0, 1'b1));
        waitDone("wrap", W);
        idle(2);

        applyStimulus(16'h5A5A, 16'h5A5A, 1'b1, 1'b1, mk(16'hFFFF, 1'b1, 1'b0, 1'b0, 1'b1));
        waitDone("borrow_in", W);
        idle(2);

        applyStimulus(16'h8000, 16'h0001, 1'b0, 1'b1, mk(16'h7FFF, 1'b0, 1'b1, 1'b0, 1'b0));
        waitDone("overflow", W);
        idle(2);

        applyStimulus(16'hABCD, 16'hABCD, 1'b0, 1'b1, mk(16'h0000, 1'b0, 1'b0, 1'b1, 1'b0));
        waitDone("zero", W);
        idle(2);

        // Back-to-back: second start issued during the first DONE cycle.
        applyStimulus(16'h0030, 16'h0010, 1'b0, 1'b1, mk(16'h0020, 1'b0, 1'b0, 1'b0, 1'b0));
        waitDone("b2b_first", W);
        applyStimulus(16'h0010, 16'h0008, 1'b0, 1'b1, mk(16'h0008, 1'b0, 1'b0, 1'b0, 1'b0));
        waitDone("b2b_second", W);
        idle(3);
        checkOutput("D_held", 64'(D), 64'(16'h0008));

        // Start held high through the whole operation with operands changing underneath.
        A     = 16'h4000;
        B     = 16'h1000;
        Bin   = 1'b0;
        start = 1'b1;
        expQ.push_back(mk(16'h3000, 1'b0, 1'b0, 1'b0, 1'b0));
        @(posedge clk);
        #1;
        A   = 16'hFFFF;
        B   = 16'h1234;
        Bin = 1'b1;
        waitDone("held_start", W);
        start = 1'b0;
        idle(25);

`ifdef SERIAL_SUB_ADD_EN
        addSel = 1'b1;
        applyStimulus(16'h7FFF, 16'h0001, 1'b0, 1'b1, mk(16'h8000, 1'b0, 1'b1, 1'b0, 1'b1));
        waitDone("add_overflow", W);
        idle(2);
        applyStimulus(16'hFFFF, 16'h0001, 1'b0, 1'b1, mk(16'h0000, 1'b1, 1'b0, 1'b1, 1'b0));
        waitDone("add_carry", W);
        addSel = 1'b0;
        idle(2);
`endif

        idle(5);
        checkOutput("queue_drained", 64'(expQ.size()), 64'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
